// File: rtl/addsub_ovf_acc.sv
// Add/subtract accumulator with wrap/saturate overflow handling, per-command flags and overflow event tracking.
// Latency 1 cycle, command to registered outputs; one command per cycle, no backpressure.
module addsub_ovf_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic             sat,
  output logic [WIDTH-1:0] acc,
  output logic             out_valid,
  output logic             ovf,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_cnt
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLRF = 2'b11;

  localparam logic [WIDTH-1:0] ACC_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ACC_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             is_sub;
  logic             is_arith;
  logic [WIDTH-1:0] b_opnd;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] raw;
  logic             ovf_raw;
  logic [WIDTH-1:0] nxt_acc;
  logic             nxt_ovf;
  logic             nxt_carry;

  // SUB is acc + ~din + 1, so one adder serves both operations.
  always_comb begin
    is_sub   = (op == OP_SUB);
    is_arith = (op == OP_ADD) || (op == OP_SUB);
    b_opnd   = is_sub ? ~din : din;
    sum      = {1'b0, acc} + {1'b0, b_opnd} + (WIDTH+1)'(is_sub);
    raw      = sum[WIDTH-1:0];
    if (is_sub)
      ovf_raw = (acc[WIDTH-1] != din[WIDTH-1]) && (raw[WIDTH-1] != acc[WIDTH-1]);
    else
      ovf_raw = (acc[WIDTH-1] == din[WIDTH-1]) && (raw[WIDTH-1] != acc[WIDTH-1]);

    nxt_acc   = acc;
    nxt_ovf   = 1'b0;
    nxt_carry = 1'b0;
    case (op)
      OP_LOAD: nxt_acc = din;
      OP_ADD, OP_SUB: begin
        // Saturation direction follows the sign of the pre-command accumulator.
        nxt_acc   = (ovf_raw && sat) ? (acc[WIDTH-1] ? ACC_MIN : ACC_MAX) : raw;
        nxt_ovf   = ovf_raw;
        nxt_carry = is_sub ? ~sum[WIDTH] : sum[WIDTH];
      end
      default: nxt_acc = acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      out_valid  <= 1'b0;
      ovf        <= 1'b0;
      carry      <= 1'b0;
      zero       <= 1'b1;
      neg        <= 1'b0;
      ovf_sticky <= 1'b0;
      ovf_cnt    <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        acc   <= nxt_acc;
        ovf   <= nxt_ovf;
        carry <= nxt_carry;
        zero  <= (nxt_acc == '0);
        neg   <= nxt_acc[WIDTH-1];
        if (op == OP_CLRF) begin
          ovf_sticky <= 1'b0;
          ovf_cnt    <= '0;
        end else if (is_arith && ovf_raw) begin
          ovf_sticky <= 1'b1;
          if (ovf_cnt != '1)
            ovf_cnt <= ovf_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_ovf_acc.sv
// Directed self-checking bench for addsub_ovf_acc at WIDTH=8, CNT_W=4.
module tb_addsub_ovf_acc;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] op;
  logic [7:0] din;
  logic       sat;
  logic [7:0] acc;
  logic       out_valid;
  logic       ovf;
  logic       carry;
  logic       zero;
  logic       neg;
  logic       ovf_sticky;
  logic [3:0] ovf_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] ADD  = 2'b01;
  localparam logic [1:0] SUB  = 2'b10;
  localparam logic [1:0] CLRF = 2'b11;

  addsub_ovf_acc #(.WIDTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .op         (op),
    .din        (din),
    .sat        (sat),
    .acc        (acc),
    .out_valid  (out_valid),
    .ovf        (ovf),
    .carry      (carry),
    .zero       (zero),
    .neg        (neg),
    .ovf_sticky (ovf_sticky),
    .ovf_cnt    (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Presents one command for one edge and samples 1 time unit after it.
  task automatic do_cmd(input logic [1:0] o, input logic [7:0] d, input logic s);
    in_valid = 1'b1;
    op       = o;
    din      = d;
    sat      = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1; op = LOAD; din = 8'h55; sat = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (acc !== 8'h00) begin errors++; $display("FAIL reset_discard acc: got %h exp 00", acc); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_discard out_valid: got %b exp 0", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    idle();
    checks++; if (acc !== 8'h00) begin errors++; $display("FAIL reset_idle acc: got %h exp 00", acc); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_idle zero: got %b exp 1", zero); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle out_valid: got %b exp 0", out_valid); end
    checks++; if (ovf_cnt !== 4'h0) begin errors++; $display("FAIL reset_idle ovf_cnt: got %h exp 0", ovf_cnt); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_idle ovf_sticky: got %b exp 0", ovf_sticky); end
  endtask

  task automatic test_add_wrap();
    do_cmd(LOAD, 8'h7F, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL load out_valid: got %b exp 1", out_valid); end
    checks++; if (acc !== 8'h7F) begin errors++; $display("FAIL load acc: got %h exp 7f", acc); end
    do_cmd(ADD, 8'h01, 1'b0);
    checks++; if (acc !== 8'h80) begin errors++; $display("FAIL add_wrap acc: got %h exp 80", acc); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL add_wrap ovf: got %b exp 1", ovf); end
    checks++; if (neg !== 1'b1) begin errors++; $display("FAIL add_wrap neg: got %b exp 1", neg); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL add_wrap carry: got %b exp 0", carry); end
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL add_wrap ovf_sticky: got %b exp 1", ovf_sticky); end
    checks++; if (ovf_cnt !== 4'h1) begin errors++; $display("FAIL add_wrap ovf_cnt: got %h exp 1", ovf_cnt); end
    idle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_hold out_valid: got %b exp 0", out_valid); end
    checks++; if (acc !== 8'h80) begin errors++; $display("FAIL idle_hold acc: got %h exp 80", acc); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL idle_hold ovf: got %b exp 1", ovf); end
  endtask

  task automatic test_add_sat();
    do_cmd(CLRF, 8'h00, 1'b0);
    checks++; if (acc !== 8'h80) begin errors++; $display("FAIL clrf acc: got %h exp 80", acc); end
    checks++; if (ovf_cnt !== 4'h0) begin errors++; $display("FAIL clrf ovf_cnt: got %h exp 0", ovf_cnt); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clrf ovf: got %b exp 0", ovf); end
    do_cmd(LOAD, 8'h7F, 1'b1);
    do_cmd(ADD, 8'h01, 1'b1);
    checks++; if (acc !== 8'h7F) begin errors++; $display("FAIL add_sat acc: got %h exp 7f", acc); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL add_sat ovf: got %b exp 1", ovf); end
    checks++; if (neg !== 1'b0) begin errors++; $display("FAIL add_sat neg: got %b exp 0", neg); end
    checks++; if (ovf_cnt !== 4'h1) begin errors++; $display("FAIL add_sat ovf_cnt: got %h exp 1", ovf_cnt); end
  endtask

  task automatic test_sub_sat();
    do_cmd(LOAD, 8'h80, 1'b1);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL load_clr ovf: got %b exp 0", ovf); end
    do_cmd(SUB, 8'h01, 1'b1);
    checks++; if (acc !== 8'h80) begin errors++; $display("FAIL sub_sat acc: got %h exp 80", acc); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sub_sat ovf: got %b exp 1", ovf); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL sub_sat carry: got %b exp 0", carry); end
    checks++; if (ovf_cnt !== 4'h2) begin errors++; $display("FAIL sub_sat ovf_cnt: got %h exp 2", ovf_cnt); end
  endtask

  task automatic test_sub_zero();
    do_cmd(LOAD, 8'h05, 1'b0);
    do_cmd(SUB, 8'h05, 1'b0);
    checks++; if (acc !== 8'h00) begin errors++; $display("FAIL sub_zero acc: got %h exp 00", acc); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL sub_zero zero: got %b exp 1", zero); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sub_zero ovf: got %b exp 0", ovf); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL sub_zero carry: got %b exp 0", carry); end
    checks++; if (ovf_cnt !== 4'h2) begin errors++; $display("FAIL sub_zero ovf_cnt: got %h exp 2", ovf_cnt); end
  endtask

  task automatic test_most_neg_and_carry();
    do_cmd(LOAD, 8'h00, 1'b0);
    do_cmd(SUB, 8'h80, 1'b0);
    checks++; if (acc !== 8'h80) begin errors++; $display("FAIL most_neg acc: got %h exp 80", acc); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL most_neg ovf: got %b exp 1", ovf); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL most_neg borrow: got %b exp 1", carry); end
    do_cmd(LOAD, 8'hFF, 1'b0);
    checks++; if (neg !== 1'b1) begin errors++; $display("FAIL load_neg neg: got %b exp 1", neg); end
    do_cmd(ADD, 8'h01, 1'b0);
    checks++; if (acc !== 8'h00) begin errors++; $display("FAIL add_carry acc: got %h exp 00", acc); end
    checks++; if (carry !== 1'b1) begin errors++; $display("FAIL add_carry carry: got %b exp 1", carry); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL add_carry ovf: got %b exp 0", ovf); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL add_carry zero: got %b exp 1", zero); end
    checks++; if (ovf_cnt !== 4'h3) begin errors++; $display("FAIL add_carry ovf_cnt: got %h exp 3", ovf_cnt); end
  endtask

  task automatic test_back_to_back();
    do_cmd(CLRF, 8'h00, 1'b0);
    do_cmd(LOAD, 8'h7F, 1'b1);
    for (int i = 0; i < 20; i++) begin
      do_cmd(ADD, 8'h01, 1'b1);
      if (i == 13) begin
        checks++; if (ovf_cnt !== 4'hE) begin errors++; $display("FAIL b2b_cnt14 ovf_cnt: got %h exp e", ovf_cnt); end
      end
      if (i == 14) begin
        checks++; if (ovf_cnt !== 4'hF) begin errors++; $display("FAIL b2b_cnt15 ovf_cnt: got %h exp f", ovf_cnt); end
      end
    end
    checks++; if (ovf_cnt !== 4'hF) begin errors++; $display("FAIL b2b_held ovf_cnt: got %h exp f", ovf_cnt); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b out_valid: got %b exp 1", out_valid); end
    checks++; if (acc !== 8'h7F) begin errors++; $display("FAIL b2b acc: got %h exp 7f", acc); end
    do_cmd(CLRF, 8'h33, 1'b0);
    checks++; if (ovf_cnt !== 4'h0) begin errors++; $display("FAIL b2b_clrf ovf_cnt: got %h exp 0", ovf_cnt); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL b2b_clrf ovf_sticky: got %b exp 0", ovf_sticky); end
    checks++; if (acc !== 8'h7F) begin errors++; $display("FAIL b2b_clrf acc: got %h exp 7f", acc); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_clrf out_valid: got %b exp 1", out_valid); end
  endtask

  task automatic test_async_reset();
    do_cmd(LOAD, 8'h7F, 1'b0);
    do_cmd(ADD, 8'h05, 1'b0);
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL pre_rst ovf_sticky: got %b exp 1", ovf_sticky); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (acc !== 8'h00) begin errors++; $display("FAIL async_rst acc: got %h exp 00", acc); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst out_valid: got %b exp 0", out_valid); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL async_rst ovf: got %b exp 0", ovf); end
    checks++; if (neg !== 1'b0) begin errors++; $display("FAIL async_rst neg: got %b exp 0", neg); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL async_rst zero: got %b exp 1", zero); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL async_rst ovf_sticky: got %b exp 0", ovf_sticky); end
    checks++; if (ovf_cnt !== 4'h0) begin errors++; $display("FAIL async_rst ovf_cnt: got %h exp 0", ovf_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    do_cmd(ADD, 8'h03, 1'b0);
    checks++; if (acc !== 8'h03) begin errors++; $display("FAIL post_rst acc: got %h exp 03", acc); end
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL post_rst carry: got %b exp 0", carry); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = LOAD; din = 8'h00; sat = 1'b0;
    test_reset();
    test_add_wrap();
    test_add_sat();
    test_sub_sat();
    test_sub_zero();
    test_most_neg_and_carry();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
